// File: rtl/multiplier_4xn.sv
// multiplier_4xn: pipelined unsigned 4 x N multiplier.
// Input register stage -> three ripple-carry full-adder rows -> output register stage.
// Fixed two-edge latency, one new operation accepted every cycle, no back-pressure.
module multiplier_4xn #(
    parameter int unsigned N = 31
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [3:0]     A,
    input  logic [N-1:0]   B,
    output logic           out_valid,
    output logic [N+3:0]   P
);

    // Product width; 15 * (2^N - 1) always fits, so no row ever drops a carry.
    localparam int unsigned W = N + 4;

    // Stage 0 registers
    logic [3:0]   a_q;
    logic [N-1:0] b_q;
    logic         v_q;

    // Combinational array
    logic [W-1:0] b_ext;
    logic [W-1:0] pp [4];
    logic [W-1:0] row1;
    logic [W-1:0] row2;
    logic [W-1:0] row3;

    // Single full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
        logic s;
        logic co;
        s  = x ^ y ^ cin;
        co = (x & y) | (cin & (x ^ y));
        return {co, s};
    endfunction

    // One ripple-carry row of W full-adder cells. Operands are zero-extended to W bits,
    // so the carry out of the top cell is always zero and is dropped.
    function automatic logic [W-1:0] ripple_row(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] s;
        logic [1:0]   fa;
        logic         c;
        c = 1'b0;
        for (int unsigned k = 0; k < W; k++) begin
            fa   = full_add(x[k], y[k], c);
            s[k] = fa[0];
            c    = fa[1];
        end
        return s;
    endfunction

    // Capture operands only on a valid cycle; the valid bit follows in_valid every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            v_q <= 1'b0;
        end else begin
            v_q <= in_valid;
            if (in_valid) begin
                a_q <= A;
                b_q <= B;
            end
        end
    end

    // Partial products and the three adder rows (the critical path of the block).
    always_comb begin
        b_ext = W'(b_q);
        for (int i = 0; i < 4; i++) begin
            pp[i] = a_q[i] ? (b_ext << i) : '0;
        end
        row1 = ripple_row(pp[0], pp[1]);
        row2 = ripple_row(row1, pp[2]);
        row3 = ripple_row(row2, pp[3]);
    end

    // Register the array output so its ripple glitches never reach P; P holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            P         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v_q;
            if (v_q) begin
                P <= row3;
            end
        end
    end

endmodule

// File: tb/tb_multiplier_4xn.sv
// Bench for multiplier_4xn: N=31 and N=2 instances driven side by side.
// The driver pushes A*B with its due cycle; per-instance monitors check every cycle.
module tb_multiplier_4xn;

    typedef struct {
        logic [63:0] p;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv31, iv2;
    logic [3:0]  a31, a2;
    logic [30:0] b31;
    logic [1:0]  b2;
    logic        ov31, ov2;
    logic [34:0] p31;
    logic [5:0]  p2;

    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    exp_t q31[$];
    exp_t q2[$];
    exp_t e31, e2;
    logic [63:0] last31 = '0;
    logic [63:0] last2  = '0;

    multiplier_4xn #(.N(31)) dut31 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv31), .A(a31), .B(b31),
        .out_valid(ov31), .P(p31)
    );

    multiplier_4xn #(.N(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .A(a2), .B(b2),
        .out_valid(ov2), .P(p2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] got,
                                  input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t cyc=%0d)", name, got, exp, $time, cyc);
        end
    endfunction

    // N=31 monitor: a due entry demands valid plus the exact product; otherwise idle and hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid31", 64'(ov31), 64'd0);
            check("rst_p31", 64'(p31), 64'd0);
        end else if (q31.size() > 0 && q31[0].due == cyc) begin
            e31 = q31.pop_front();
            check("valid31", 64'(ov31), 64'd1);
            check("p31", 64'(p31), e31.p);
            last31 = e31.p;
        end else begin
            check("idle_valid31", 64'(ov31), 64'd0);
            check("hold_p31", 64'(p31), last31);
        end
    end

    // N=2 monitor, same rules.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid2", 64'(ov2), 64'd0);
            check("rst_p2", 64'(p2), 64'd0);
        end else if (q2.size() > 0 && q2[0].due == cyc) begin
            e2 = q2.pop_front();
            check("valid2", 64'(ov2), 64'd1);
            check("p2", 64'(p2), e2.p);
            last2 = e2.p;
        end else begin
            check("idle_valid2", 64'(ov2), 64'd0);
            check("hold_p2", 64'(p2), last2);
        end
    end

    // Drive point: well after the rising edge, well before the sampling edge.
    task automatic slot();
        @(posedge clk);
        #2;
    endtask

    // Apply operands to both instances and record what each must produce two edges on.
    task automatic apply(input logic [3:0] x31, input logic [30:0] y31, input logic v31,
                         input logic [3:0] x2, input logic [1:0] y2, input logic v2);
        a31  = x31;
        b31  = y31;
        iv31 = v31;
        a2   = x2;
        b2   = y2;
        iv2  = v2;
        if (v31) q31.push_back('{p: 64'(x31) * 64'(y31), due: cyc + 2});
        if (v2)  q2.push_back('{p: 64'(x2) * 64'(y2), due: cyc + 2});
    endtask

    task automatic idle();
        apply(4'd0, 31'd0, 1'b0, 4'd0, 2'd0, 1'b0);
    endtask

    logic [3:0]  ca  [3];
    logic [30:0] cb  [3];
    logic [3:0]  ca2 [3];
    logic [1:0]  cb2 [3];

    initial begin
        // Reset held with a full-scale operation pending on the inputs.
        rst_n = 1'b0;
        iv31 = 1'b1; a31 = 4'hF; b31 = '1;
        iv2  = 1'b1; a2  = 4'hF; b2  = '1;
        repeat (3) slot();

        // Release between edges with inputs held: first product two edges later.
        rst_n = 1'b1;
        apply(4'hF, '1, 1'b1, 4'hF, 2'd3, 1'b1);
        slot(); idle();
        repeat (2) begin slot(); idle(); end

        // Directed corners.
        ca[0] = 4'd0;  cb[0] = 31'h7FFFFFFF; ca2[0] = 4'd15; cb2[0] = 2'd3;
        ca[1] = 4'd1;  cb[1] = 31'h12345678; ca2[1] = 4'd0;  cb2[1] = 2'd3;
        ca[2] = 4'd15; cb[2] = 31'h7FFFFFFF; ca2[2] = 4'd15; cb2[2] = 2'd0;
        for (int i = 0; i < 3; i++) begin
            slot(); apply(ca[i], cb[i], 1'b1, ca2[i], cb2[i], 1'b1);
            slot(); idle();
            slot(); idle();
        end

        // Streaming burst of three, then idle so P must hold the last product.
        ca[0] = 4'd3;  cb[0] = 31'd5; ca2[0] = 4'd3; cb2[0] = 2'd1;
        ca[1] = 4'd7;  cb[1] = 31'd9; ca2[1] = 4'd2; cb2[1] = 2'd3;
        ca[2] = 4'd15; cb[2] = 31'd1; ca2[2] = 4'd1; cb2[2] = 2'd2;
        for (int i = 0; i < 3; i++) begin
            slot(); apply(ca[i], cb[i], 1'b1, ca2[i], cb2[i], 1'b1);
        end
        repeat (4) begin slot(); idle(); end

        // Random traffic with occasional bubbles, both widths.
        for (int i = 0; i < 8 * 31 + 40; i++) begin
            slot();
            apply(4'($urandom_range(0, 15)), 31'($urandom), ($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0));
        end
        repeat (3) begin slot(); idle(); end

        // Leave a nonzero product on P, then reset while 9*100 is in flight.
        slot(); apply(4'd5, 31'd7, 1'b1, 4'd7, 2'd3, 1'b1);
        repeat (3) begin slot(); idle(); end
        slot(); apply(4'd9, 31'd100, 1'b1, 4'd9, 2'd2, 1'b1);
        slot();
        idle();
        rst_n = 1'b0;
        q31.delete();
        q2.delete();
        last31 = '0;
        last2  = '0;
        #1;
        check("async_rst_p31", 64'(p31), 64'd0);
        check("async_rst_valid31", 64'(ov31), 64'd0);
        check("async_rst_p2", 64'(p2), 64'd0);
        check("async_rst_valid2", 64'(ov2), 64'd0);
        repeat (2) slot();
        rst_n = 1'b1;
        repeat (4) begin slot(); idle(); end

        // One more operation after recovery, then drain.
        slot(); apply(4'd6, 31'd1000, 1'b1, 4'd15, 2'd3, 1'b1);
        repeat (4) begin slot(); idle(); end

        check("drain31", 64'(q31.size()), 64'd0);
        check("drain2", 64'(q2.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/multiplier_4xn.md
# multiplier_4xn

Pipelined unsigned multiplier that forms the exact product of a 4-bit operand and an N-bit operand. It is built as a shift-and-add array of full-adder rows between an input register stage and an output register stage. It sits as a standalone arithmetic datapath block with fixed two-cycle latency and one new operation accepted per cycle.

## Interface
- N, default 31: width of operand B; legal range N >= 2; product width is N+4.

- clk  input  1  rising-edge clock for all registers
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  A/B carry a new operation this cycle
- A  input  4  unsigned multiplicand
- B  input  N  unsigned multiplier
- out_valid  output  1  P holds a valid product this cycle
- P  output  N+4  unsigned product A*B

One clock; reset is asynchronous and active-low. Ports are clk and rst_n.

## Operation
- Stage 0, the input registers:
  - On a rising clk edge with in_valid=1, capture A into a_q and B into b_q, and set v_q=1.
  - On an edge with in_valid=0, a_q and b_q hold their values and v_q=0.
- Combinational array:
  - Partial products are pp_i = a_q[i] ? (b_q << i) : 0, for i = 0..3.
  - Sum them with three ripple-carry adder rows built from full-adder cells: row1 = pp0+pp1, row2 = row1+pp2, row3 = row2+pp3.
  - Each row is zero-extended so that no carry is lost. The final sum is exactly N+4 bits.
- Stage 1, the output registers:
  - On every rising edge, P <= row3 when v_q=1. Otherwise P holds its value.
  - out_valid <= v_q.
- Arithmetic:
  - Unsigned only; the result is exact.
  - Maximum result is 15*(2^N - 1), which is less than 2^(N+4), so no overflow or truncation occurs.
  - N is not restricted to 31.
- Reset (rst_n=0, asynchronous, at any time including mid-operation):
  - a_q, b_q, v_q, P and out_valid all go to 0 immediately.
  - Any in-flight operation is discarded.
  - After rst_n deasserts, the first capture happens on the next rising edge with in_valid=1.
- P changes only on rising edges or on reset; glitches from the array never appear on P.

## Timing
- Throughput: one operation per cycle; no back-pressure.
- Latency: 2 rising edges.
  - Operands presented with in_valid=1 before edge k are captured at edge k.
  - The product appears on P with out_valid=1 after edge k+1 and stays there at least until edge k+2.
- Back-to-back operations on consecutive edges produce consecutive products in order, each with out_valid=1.
- Idle cycles (in_valid=0) produce out_valid=0 one edge later. P keeps the last valid product.
- Reset values: P=0, out_valid=0.
- Critical path is the 3-row ripple array, roughly 3*(N+4) full-adder delays. The clock period must accommodate it; no internal pipelining inside the array.

## Test plan
- Reset: hold rst_n=0, drive in_valid=1, A=4'hF, B=all ones; then release between edges -> P=0 and out_valid=0 throughout reset. With inputs held, the first product appears 2 edges after release.
- Directed corners, N=31:
  - A=0, B=0x7FFFFFFF -> P=0.
  - A=1, B=0x12345678 -> P=0x12345678.
  - A=15, B=0x7FFFFFFF -> P=0x77FFFFFF1.
  - Each result appears with out_valid=1 exactly 2 edges after capture.
- Pipeline streaming, N=31: pulse in_valid=1 for 3 consecutive cycles with (A,B) = (3,5), (7,9), (15,1), then in_valid=0 -> P sequence is 15, 63, 15 on consecutive cycles. out_valid is 1,1,1 and then drops to 0; P holds 15.
- Randomized, N=31 and N=2: 8*N random pairs, unsigned A in 0..15 and B in 0..2^N-1 -> P equals A*B for every pair; zero mismatches.
- Reset mid-operation: capture A=9, B=100, then assert rst_n=0 before the next edge -> P and out_valid go to 0 immediately, and no product 900 is ever output.
- Small width, N=2: A=15, B=3 -> P=45 (6'b101101), full width with no truncation.
